mandelbrot_frame_ctrl: RTL and testbench
========================================

# mandelbrot_frame_ctrl

Frame-level sequencer for the `mandelbrot` pixel core. It issues one `run` pulse per pixel, captures each 4-bit iteration code when the pixel completes, and buffers the codes in a small FIFO. The FIFO feeds a valid/ready pixel stream to the display/readout logic, and `run` is withheld while that buffer is full. It also drives the core's view configuration (`scaling`, `cr_offset`, `ci_offset`) and optionally animates a zoom across successive frames.

## Interface
Parameters:
- `BITWIDTH`, 10: width of the offset ports; matches the core.
- `WIDTH`, 320: pixels per line; used only for the zoom re-centring step.
- `HEIGHT`, 240: lines per frame; used only for the zoom re-centring step.
- `DEPTH`, 4: pixel FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level; frames are generated while high.
- `cfg_scaling` in 7: initial scaling; sampled at frame start.
- `cfg_cr` in BITWIDTH: initial real offset; sampled at frame start.
- `cfg_ci` in BITWIDTH: initial imaginary offset; sampled at frame start.
- `core_run` out 1: one-cycle start pulse to the core.
- `core_running` in 1: core busy flag.
- `core_finished` in 1: core frame-complete flag.
- `core_ctr` in 4: core iteration code.
- `scaling` out 7: to the core.
- `cr_offset` out BITWIDTH: to the core.
- `ci_offset` out BITWIDTH: to the core.
- `pix_data` out 4: FIFO head data.
- `pix_last` out 1: FIFO head is the last pixel of its frame.
- `pix_valid` out 1: FIFO non-empty.
- `pix_ready` in 1: consumer accepts the head entry.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `frame_cnt` out 8: completed frames; wraps at 255 -> 0.
- `busy` out 1: state is not IDLE.

## Operation
- FSM has five states: IDLE, LOAD, ISSUE, WAIT, FEND.
- **IDLE**
  - `enable`=1 -> LOAD.
- **LOAD**
  - Register `cfg_*` into `scaling`/`cr_offset`/`ci_offset`.
  - -> ISSUE.
- **ISSUE**
  - If FIFO count < DEPTH: assert `core_run` for 1 cycle, clear `seen_run`, -> WAIT.
  - Otherwise stay in ISSUE.
  - Only one pixel is ever in flight, so a free slot at issue guarantees room at push.
- **WAIT**
  - Set `seen_run` when `core_running`=1.
  - When `seen_run`=1 and `core_running`=0: push `{core_finished, core_ctr}` into the FIFO.
  - After the push: if `core_finished`=1 -> FEND, else -> ISSUE.
- **FEND**
  - Pulse `frame_done` and increment `frame_cnt`.
  - Apply the zoom step (see Configuration).
  - `enable`=1 -> ISSUE; otherwise -> IDLE.
  - The next frame reloads `cfg_*` only through IDLE -> LOAD, or when the zoom wraps.
- Dropping `enable` mid-frame does not abort: the current frame completes, then the FSM goes to IDLE.
- FIFO:
  - Show-ahead; `pix_data`/`pix_last` present the head whenever `pix_valid`=1.
  - An entry pops on `pix_valid & pix_ready`.
  - A push and a pop in the same cycle leave the count unchanged.
  - `pix_ready` while empty has no effect.
- The view outputs change only in LOAD and FEND, i.e. while the core is stopped with `finished`=1. This is when the core latches the offsets.

## Timing
- Reset values:
  - State IDLE, FIFO empty.
  - `core_run`, `pix_valid`, `pix_last`, `frame_done`, `busy` = 0.
  - `pix_data` = 0, `frame_cnt` = 0.
  - `scaling`, `cr_offset`, `ci_offset` = 0.
- Reset mid-operation clears everything immediately, including FIFO contents. The core shares `rst_n`.
- Start latency:
  - `enable` rises in cycle 0.
  - LOAD in cycle 1.
  - `core_run` high in cycle 2.
- Pixel latency: the push occurs on the first cycle with `core_running`=0 after `seen_run`. `pix_valid` rises on the following cycle.
- Issue overhead is 2 cycles per pixel beyond core compute time (WAIT->ISSUE, ISSUE->core).
- `frame_done` is asserted in the cycle after the last pixel's push.

## Configuration
- Macro: `MANDELBROT_ZOOM_ANIM_EN`.
- Defined: in FEND, if `scaling` > 0:
  - `scaling` <= `scaling`-1.
  - `cr_offset` += WIDTH/2, `ci_offset` += HEIGHT/2 (mod 2^BITWIDTH). This keeps the image centre fixed.
- Defined, with `scaling`=0 at FEND: reload from `cfg_*` instead (zoom loop).
- Not defined: FEND leaves the view registers unchanged, so every frame renders the same view.

## Structure
- Package `mandelbrot_pkg` holds:
  - The FSM state enum.
  - The FIFO entry typedef (`last`, `data[3:0]`).
  - The pixel-code width constant 4.
- Sub-module `mandelbrot_pix_fifo` is parameterised by DEPTH and has push, pop, count, full and empty.
- The top level contains the FSM and the view registers.

## Test plan
- Reset while busy with 3 entries in the FIFO -> all outputs at reset values, `pix_valid`=0 in the same cycle.
- Core model with WIDTH=4, HEIGHT=2, `pix_ready`=1 -> 8 pushes, `pix_last`=1 only on the 8th, one `frame_done`, `frame_cnt`=1.
- `pix_ready`=0, DEPTH=4 -> exactly 4 `core_run` pulses, FSM parked in ISSUE. Raising `pix_ready` resumes issue and no pixel is lost.
- Simultaneous push and pop at count=DEPTH-1 -> count stays DEPTH-1 and data order is preserved.
- With the macro, `cfg_scaling`=2, `cfg_cr`=0x300, `cfg_ci`=0x380:
  - After frame 1: scaling 1, cr 0x3A0, ci 0x3F8.
  - After frame 2: scaling 0, cr 0x040 (wrapped), ci 0x070.
  - After frame 3: scaling 2, cr 0x300, ci 0x380 (reloaded).
- `enable` cleared mid-frame -> the frame completes, then `busy`=0. Without the macro the view is unchanged across frames.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types for the mandelbrot frame sequencer: FSM states, pixel FIFO entry.
package mandelbrot_pkg;

    localparam int unsigned PIX_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        FEND  = 3'd4
    } state_e;

    typedef struct packed {
        logic             last;
        logic [PIX_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/mandelbrot_frame_ctrl_if.sv
// Valid/ready pixel stream from the frame sequencer to the readout logic.
interface mandelbrot_frame_ctrl_if;

    logic [mandelbrot_pkg::PIX_W-1:0] pix_data;
    logic                             pix_last;
    logic                             pix_valid;
    logic                             pix_ready;

    modport master (
        output pix_data,
        output pix_last,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_last,
        input  pix_valid,
        output pix_ready
    );

endinterface

// File: rtl/mandelbrot_pix_fifo.sv
// Show-ahead pixel FIFO; DEPTH must be a power of two, at least 2.
// Reset clears the storage as well as the pointers so the head reads as zero.
module mandelbrot_pix_fifo
    import mandelbrot_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fifo_entry_t      push_data,
    input  logic             pop,
    output fifo_entry_t      head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fifo_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             full_q;
    logic             empty_q;
    logic             do_push;
    logic             do_pop;

    // Qualify requests: a pop on empty is ignored, a push on full only with a pop.
    always_comb begin
        do_pop  = pop && !empty_q;
        do_push = push && (!full_q || do_pop);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage, pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/mandelbrot_frame_ctrl.sv
// Frame-level sequencer for the mandelbrot pixel core: issues one run per
// pixel, buffers iteration codes in a FIFO, owns the view configuration.
// Optional zoom animation across frames: define MANDELBROT_ZOOM_ANIM_EN.
module mandelbrot_frame_ctrl
    import mandelbrot_pkg::*;
#(
    parameter int unsigned BITWIDTH = 10,
    parameter int unsigned WIDTH    = 320,
    parameter int unsigned HEIGHT   = 240,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [6:0]          cfg_scaling,
    input  logic [BITWIDTH-1:0] cfg_cr,
    input  logic [BITWIDTH-1:0] cfg_ci,
    output logic                core_run,
    input  logic                core_running,
    input  logic                core_finished,
    input  logic [PIX_W-1:0]    core_ctr,
    output logic [6:0]          scaling,
    output logic [BITWIDTH-1:0] cr_offset,
    output logic [BITWIDTH-1:0] ci_offset,
    mandelbrot_frame_ctrl_if.master pix,
    output logic                frame_done,
    output logic [7:0]          frame_cnt,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [BITWIDTH-1:0] CR_STEP = BITWIDTH'(WIDTH / 2);
    localparam logic [BITWIDTH-1:0] CI_STEP = BITWIDTH'(HEIGHT / 2);
`ifdef MANDELBROT_ZOOM_ANIM_EN
    localparam bit ZOOM_EN = 1'b1;
`else
    localparam bit ZOOM_EN = 1'b0;
`endif

    state_e              state_q;
    state_e              state_d;
    logic                seen_run_q;
    logic                seen_run_d;
    logic                push_c;
    logic                pop_c;
    logic                room_c;
    logic                core_run_d;
    logic                busy_d;
    logic                frame_done_d;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                fifo_full;
    logic                fifo_empty;
    fifo_entry_t         push_entry;
    fifo_entry_t         head;
    logic [6:0]          scaling_d;
    logic [BITWIDTH-1:0] cr_d;
    logic [BITWIDTH-1:0] ci_d;

    mandelbrot_pix_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_c),
        .push_data (push_entry),
        .pop       (pop_c),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop_c          = !fifo_empty && pix.pix_ready;
    assign pix.pix_valid  = !fifo_empty;
    assign pix.pix_data   = head.data;
    assign pix.pix_last   = head.last;
    assign push_entry     = '{last: core_finished, data: core_ctr};

    // Next state, push request and the next values of the registered outputs.
    // core_run is registered, so it is decided from the state and FIFO
    // occupancy that will hold in the coming cycle.
    always_comb begin
        state_d    = state_q;
        seen_run_d = seen_run_q;
        push_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = ISSUE;
            end
            ISSUE: begin
                if (core_run) begin
                    seen_run_d = 1'b0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (core_running) begin
                    seen_run_d = 1'b1;
                end else if (seen_run_q) begin
                    push_c  = 1'b1;
                    state_d = core_finished ? FEND : ISSUE;
                end
            end
            FEND: begin
                state_d = enable ? ISSUE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cnt_nxt      = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);
        room_c       = fifo_full ? pop_c : (cnt_nxt != CNT_W'(DEPTH));
        core_run_d   = (state_d == ISSUE) && (state_q != ISSUE || !core_run) && room_c;
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == FEND);
    end

    // View registers change only in LOAD and FEND, while the core is stopped.
    always_comb begin
        scaling_d = scaling;
        cr_d      = cr_offset;
        ci_d      = ci_offset;
        if (state_q == LOAD) begin
            scaling_d = cfg_scaling;
            cr_d      = cfg_cr;
            ci_d      = cfg_ci;
        end else if (state_q == FEND && ZOOM_EN) begin
            if (scaling != 7'd0) begin
                // Halving the pixel step doubles the zoom; shift the origin
                // by half a frame so the image centre stays put.
                scaling_d = scaling - 7'd1;
                cr_d      = cr_offset + CR_STEP;
                ci_d      = ci_offset + CI_STEP;
            end else begin
                scaling_d = cfg_scaling;
                cr_d      = cfg_cr;
                ci_d      = cfg_ci;
            end
        end
    end

    // FSM state, in-flight tracking and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seen_run_q <= 1'b0;
            core_run   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 8'd0;
            scaling    <= 7'd0;
            cr_offset  <= '0;
            ci_offset  <= '0;
        end else begin
            state_q    <= state_d;
            seen_run_q <= seen_run_d;
            core_run   <= core_run_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            frame_cnt  <= frame_cnt + 8'(frame_done_d);
            scaling    <= scaling_d;
            cr_offset  <= cr_d;
            ci_offset  <= ci_d;
        end
    end

endmodule

// File: tb/tb_mandelbrot_frame_ctrl.sv
// Directed bench for mandelbrot_frame_ctrl with a behavioural pixel-core model
// producing 8-pixel frames. Zoom expectations follow MANDELBROT_ZOOM_ANIM_EN.
module tb_mandelbrot_frame_ctrl;
    import mandelbrot_pkg::*;

    localparam int NPIX = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] cfg_scaling = 7'd0;
    logic [9:0] cfg_cr = 10'd0;
    logic [9:0] cfg_ci = 10'd0;
    logic       core_run;
    logic       core_running;
    logic       core_finished;
    logic [3:0] core_ctr;
    logic [6:0] scaling;
    logic [9:0] cr_offset;
    logic [9:0] ci_offset;
    logic       frame_done;
    logic [7:0] frame_cnt;
    logic       busy;

    mandelbrot_frame_ctrl_if pix_if ();

    mandelbrot_frame_ctrl #(
        .BITWIDTH (10),
        .WIDTH    (320),
        .HEIGHT   (240),
        .DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cfg_scaling   (cfg_scaling),
        .cfg_cr        (cfg_cr),
        .cfg_ci        (cfg_ci),
        .core_run      (core_run),
        .core_running  (core_running),
        .core_finished (core_finished),
        .core_ctr      (core_ctr),
        .scaling       (scaling),
        .cr_offset     (cr_offset),
        .ci_offset     (ci_offset),
        .pix           (pix_if),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Iteration codes the core model returns for pixels 0..7 of every frame.
    logic [3:0] codes [NPIX] = '{4'd1, 4'd4, 4'd7, 4'd10, 4'd13, 4'd0, 4'd3, 4'd6};

    // Core model: running for 1..3 cycles after run, finished on pixel 7.
    logic       m_running, m_finished, m_done;
    logic [3:0] m_ctr;
    int         m_idx, m_rem, m_cmpl;
    assign core_running  = m_running;
    assign core_finished = m_finished;
    assign core_ctr      = m_ctr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_running  <= 1'b0;
            m_finished <= 1'b0;
            m_done     <= 1'b0;
            m_ctr      <= 4'd0;
            m_idx      <= 0;
            m_rem      <= 0;
            m_cmpl     <= 0;
        end else begin
            m_done <= 1'b0;
            if (core_run) begin
                m_running  <= 1'b1;
                m_finished <= 1'b0;
                m_rem      <= 1 + (m_idx % 3);
            end else if (m_running) begin
                if (m_rem <= 1) begin
                    m_running  <= 1'b0;
                    m_ctr      <= codes[m_idx];
                    m_finished <= (m_idx == NPIX - 1);
                    m_idx      <= (m_idx == NPIX - 1) ? 0 : m_idx + 1;
                    m_done     <= 1'b1;
                    m_cmpl     <= m_cmpl + 1;
                end else begin
                    m_rem <= m_rem - 1;
                end
            end
        end
    end

    // Observation: accepted pixels, run pulses, frame_done pulses.
    logic [4:0] got_q [$];
    int run_cnt = 0;
    int done_cnt = 0;
    int checks = 0;
    int errors = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_if.pix_valid && pix_if.pix_ready) got_q.push_back({pix_if.pix_last, pix_if.pix_data});
            if (core_run) run_cnt++;
            if (frame_done) done_cnt++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        enable = 1'b0;
        pix_if.pix_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        run_cnt = 0;
        done_cnt = 0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt < target) begin
            errors++;
            $display("FAIL wait_done: frame_done count %0d, required %0d within %0d cycles", done_cnt, target, budget);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        do_reset();
        @(negedge clk);
        checks += 10;
        if (core_run !== 1'b0)       begin errors++; $display("FAIL rst core_run: got %b want 0", core_run); end
        if (pix_if.pix_valid !== 1'b0) begin errors++; $display("FAIL rst pix_valid: got %b want 0", pix_if.pix_valid); end
        if (pix_if.pix_last !== 1'b0)  begin errors++; $display("FAIL rst pix_last: got %b want 0", pix_if.pix_last); end
        if (pix_if.pix_data !== 4'd0)  begin errors++; $display("FAIL rst pix_data: got %0d want 0", pix_if.pix_data); end
        if (frame_done !== 1'b0)     begin errors++; $display("FAIL rst frame_done: got %b want 0", frame_done); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL rst busy: got %b want 0", busy); end
        if (frame_cnt !== 8'd0)      begin errors++; $display("FAIL rst frame_cnt: got %0d want 0", frame_cnt); end
        if (scaling !== 7'd0)        begin errors++; $display("FAIL rst scaling: got %0d want 0", scaling); end
        if (cr_offset !== 10'd0)     begin errors++; $display("FAIL rst cr_offset: got %h want 0", cr_offset); end
        if (ci_offset !== 10'd0)     begin errors++; $display("FAIL rst ci_offset: got %h want 0", ci_offset); end

        // Fill three FIFO entries with the consumer stalled, then reset.
        cfg_scaling = 7'd2; cfg_cr = 10'h300; cfg_ci = 10'h380;
        @(posedge clk); #1;
        enable = 1'b1;
        while (m_cmpl < 3 && n < 200) begin @(posedge clk); #1; n++; end
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (pix_if.pix_valid !== 1'b1) begin errors++; $display("FAIL pre-rst pix_valid: got %b want 1", pix_if.pix_valid); end
        if (busy !== 1'b1)           begin errors++; $display("FAIL pre-rst busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (pix_if.pix_valid !== 1'b0) begin errors++; $display("FAIL midrst pix_valid: got %b want 0", pix_if.pix_valid); end
        if (busy !== 1'b0)           begin errors++; $display("FAIL midrst busy: got %b want 0", busy); end
        if (core_run !== 1'b0)       begin errors++; $display("FAIL midrst core_run: got %b want 0", core_run); end
        if (scaling !== 7'd0)        begin errors++; $display("FAIL midrst scaling: got %0d want 0", scaling); end
        if (pix_if.pix_data !== 4'd0)  begin errors++; $display("FAIL midrst pix_data: got %0d want 0", pix_if.pix_data); end
        rst_n = 1'b1;
        enable = 1'b0;
    endtask

    task automatic test_single_frame();
        logic [4:0] exp;
        do_reset();
        cfg_scaling = 7'd2; cfg_cr = 10'h300; cfg_ci = 10'h380;
        pix_if.pix_ready = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0)     begin errors++; $display("FAIL start c0 busy: got %b want 0", busy); end
        if (core_run !== 1'b0) begin errors++; $display("FAIL start c0 core_run: got %b want 0", core_run); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b1)     begin errors++; $display("FAIL start c1 busy: got %b want 1", busy); end
        if (core_run !== 1'b0) begin errors++; $display("FAIL start c1 core_run: got %b want 0", core_run); end
        @(negedge clk);
        checks += 4;
        if (core_run !== 1'b1)     begin errors++; $display("FAIL start c2 core_run: got %b want 1", core_run); end
        if (scaling !== 7'd2)      begin errors++; $display("FAIL load scaling: got %0d want 2", scaling); end
        if (cr_offset !== 10'h300) begin errors++; $display("FAIL load cr: got %h want 300", cr_offset); end
        if (ci_offset !== 10'h380) begin errors++; $display("FAIL load ci: got %h want 380", ci_offset); end
        @(posedge clk); #1;
        enable = 1'b0;
        wait_done(1, 300);
        repeat (3) @(negedge clk);
        checks += 5;
        if (busy !== 1'b0)        begin errors++; $display("FAIL single busy: got %b want 0", busy); end
        if (frame_cnt !== 8'd1)   begin errors++; $display("FAIL single frame_cnt: got %0d want 1", frame_cnt); end
        if (done_cnt !== 1)       begin errors++; $display("FAIL single done pulses: got %0d want 1", done_cnt); end
        if (run_cnt !== NPIX)     begin errors++; $display("FAIL single runs: got %0d want %0d", run_cnt, NPIX); end
        if (got_q.size() !== NPIX) begin errors++; $display("FAIL single pixels: got %0d want %0d", got_q.size(), NPIX); end
        for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
            exp = {1'(i == NPIX - 1), codes[i]};
            checks++;
            if (got_q[i] !== exp) begin errors++; $display("FAIL single pix%0d: got %h want %h", i, got_q[i], exp); end
        end
`ifdef MANDELBROT_ZOOM_ANIM_EN
        checks += 3;
        if (scaling !== 7'd1)      begin errors++; $display("FAIL zoom1 scaling: got %0d want 1", scaling); end
        if (cr_offset !== 10'h3A0) begin errors++; $display("FAIL zoom1 cr: got %h want 3a0", cr_offset); end
        if (ci_offset !== 10'h3F8) begin errors++; $display("FAIL zoom1 ci: got %h want 3f8", ci_offset); end
`else
        checks += 3;
        if (scaling !== 7'd2)      begin errors++; $display("FAIL view1 scaling: got %0d want 2", scaling); end
        if (cr_offset !== 10'h300) begin errors++; $display("FAIL view1 cr: got %h want 300", cr_offset); end
        if (ci_offset !== 10'h380) begin errors++; $display("FAIL view1 ci: got %h want 380", ci_offset); end
`endif
    endtask

    task automatic test_backpressure();
        logic [4:0] exp;
        do_reset();
        pix_if.pix_ready = 1'b0;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (60) @(negedge clk);
        checks += 6;
        if (run_cnt !== 4)            begin errors++; $display("FAIL bp runs: got %0d want 4", run_cnt); end
        if (busy !== 1'b1)            begin errors++; $display("FAIL bp busy: got %b want 1", busy); end
        if (pix_if.pix_valid !== 1'b1)  begin errors++; $display("FAIL bp pix_valid: got %b want 1", pix_if.pix_valid); end
        if (core_run !== 1'b0)        begin errors++; $display("FAIL bp core_run: got %b want 0", core_run); end
        if (done_cnt !== 0)           begin errors++; $display("FAIL bp done: got %0d want 0", done_cnt); end
        if (pix_if.pix_data !== codes[0]) begin errors++; $display("FAIL bp head: got %0d want %0d", pix_if.pix_data, codes[0]); end
        @(posedge clk); #1;
        pix_if.pix_ready = 1'b1;
        wait_done(1, 300);
        repeat (3) @(negedge clk);
        checks += 4;
        if (run_cnt !== NPIX)      begin errors++; $display("FAIL bp total runs: got %0d want %0d", run_cnt, NPIX); end
        if (frame_cnt !== 8'd1)    begin errors++; $display("FAIL bp frame_cnt: got %0d want 1", frame_cnt); end
        if (busy !== 1'b0)         begin errors++; $display("FAIL bp end busy: got %b want 0", busy); end
        if (got_q.size() !== NPIX) begin errors++; $display("FAIL bp pixels: got %0d want %0d", got_q.size(), NPIX); end
        for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
            exp = {1'(i == NPIX - 1), codes[i]};
            checks++;
            if (got_q[i] !== exp) begin errors++; $display("FAIL bp pix%0d: got %h want %h", i, got_q[i], exp); end
        end
    endtask

    task automatic test_push_pop();
        logic [4:0] exp;
        int n = 0;
        do_reset();
        pix_if.pix_ready = 1'b0;
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        // Fourth completion: the push lands next edge, with three entries held.
        while (!(m_done && m_cmpl == 4) && n < 200) begin @(posedge clk); #1; n++; end
        checks++;
        if (!(m_done && m_cmpl == 4)) begin errors++; $display("FAIL pp sync: completions %0d want 4", m_cmpl); end
        pix_if.pix_ready = 1'b1;
        @(posedge clk); #1;
        pix_if.pix_ready = 1'b0;
        checks++;
        if (got_q.size() !== 1) begin errors++; $display("FAIL pp popped: got %0d want 1", got_q.size()); end
        repeat (40) @(negedge clk);
        checks += 2;
        if (run_cnt !== 5)           begin errors++; $display("FAIL pp runs: got %0d want 5", run_cnt); end
        if (pix_if.pix_valid !== 1'b1) begin errors++; $display("FAIL pp pix_valid: got %b want 1", pix_if.pix_valid); end
        @(posedge clk); #1;
        pix_if.pix_ready = 1'b1;
        wait_done(1, 300);
        repeat (3) @(negedge clk);
        checks++;
        if (got_q.size() !== NPIX) begin errors++; $display("FAIL pp pixels: got %0d want %0d", got_q.size(), NPIX); end
        for (int i = 0; i < NPIX && i < got_q.size(); i++) begin
            exp = {1'(i == NPIX - 1), codes[i]};
            checks++;
            if (got_q[i] !== exp) begin errors++; $display("FAIL pp pix%0d: got %h want %h", i, got_q[i], exp); end
        end
    endtask

    task automatic test_multi_frame();
        logic [6:0] es [3];
        logic [9:0] ecr [3];
        logic [9:0] eci [3];
        logic [4:0] exp;
`ifdef MANDELBROT_ZOOM_ANIM_EN
        es  = '{7'd1, 7'd0, 7'd2};
        ecr = '{10'h3A0, 10'h040, 10'h300};
        eci = '{10'h3F8, 10'h070, 10'h380};
`else
        es  = '{7'd2, 7'd2, 7'd2};
        ecr = '{10'h300, 10'h300, 10'h300};
        eci = '{10'h380, 10'h380, 10'h380};
`endif
        do_reset();
        cfg_scaling = 7'd2; cfg_cr = 10'h300; cfg_ci = 10'h380;
        pix_if.pix_ready = 1'b1;
        enable = 1'b1;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                @(posedge clk); #1;
                enable = 1'b0;
            end
            wait_done(f + 1, 300);
            repeat (3) @(negedge clk);
            checks += 4;
            if (scaling !== es[f])    begin errors++; $display("FAIL mf%0d scaling: got %0d want %0d", f + 1, scaling, es[f]); end
            if (cr_offset !== ecr[f]) begin errors++; $display("FAIL mf%0d cr: got %h want %h", f + 1, cr_offset, ecr[f]); end
            if (ci_offset !== eci[f]) begin errors++; $display("FAIL mf%0d ci: got %h want %h", f + 1, ci_offset, eci[f]); end
            if (frame_cnt !== 8'(f + 1)) begin errors++; $display("FAIL mf%0d frame_cnt: got %0d want %0d", f + 1, frame_cnt, f + 1); end
        end
        checks += 2;
        if (busy !== 1'b0)             begin errors++; $display("FAIL mf busy: got %b want 0", busy); end
        if (got_q.size() !== 3 * NPIX) begin errors++; $display("FAIL mf pixels: got %0d want %0d", got_q.size(), 3 * NPIX); end
        for (int i = 0; i < 3 * NPIX && i < got_q.size(); i++) begin
            exp = {1'(i % NPIX == NPIX - 1), codes[i % NPIX]};
            checks++;
            if (got_q[i] !== exp) begin errors++; $display("FAIL mf pix%0d: got %h want %h", i, got_q[i], exp); end
        end
    endtask

    initial begin
        pix_if.pix_ready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_push_pop();
        test_multi_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
